// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit
// Picks the next-PC source and its redirect address. Fetch-side prediction uses
// a bimodal table of 2-bit saturating counters and a direct-mapped BTB. Execute-side
// resolution detects jumps and mispredicts and trains the predictor.
// Optional build macro: BRU_PERF_EN adds saturating branch and mispredict counters.
module branch_redirect_unit #(
    parameter int ENTRIES = 16,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic [XLEN-1:0] pc_f,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] target_e,
    input  logic            br_valid_e,
    input  logic            br_taken_e,
    input  logic            pred_taken_e,
    input  logic [XLEN-1:0] pred_target_e,
    input  logic            jump_e,
    output logic            pred_taken_f,
    output logic [XLEN-1:0] pred_target_f,
    output logic [2:0]      pc_src,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRU_PERF_EN
    ,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispredict_cnt
`endif
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    localparam logic [2:0] SRC_SEQ      = 3'b000;
    localparam logic [2:0] SRC_PREDICT  = 3'b001;
    localparam logic [2:0] SRC_JUMP     = 3'b010;
    localparam logic [2:0] SRC_MISP_TK  = 3'b011;
    localparam logic [2:0] SRC_HOLD     = 3'b100;
    localparam logic [2:0] SRC_MISP_NT  = 3'b101;

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    // Predictor state: valid bits and counters are control, tags and targets are data.
    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [IDX-1:0]   idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             hit_f, hit_e;
    logic             mispredict;
    logic             train_jump, train_br, write_entry;
    logic [1:0]       ctr_new;
    logic             unused_pc_lsbs;

    assign idx_f = pc_f[IDX+1:2];
    assign tag_f = pc_f[XLEN-1:IDX+2];
    assign idx_e = pc_e[IDX+1:2];
    assign tag_e = pc_e[XLEN-1:IDX+2];

    // Word-aligned PCs: the two low bits never take part in indexing or tagging.
    assign unused_pc_lsbs = ^{pc_f[1:0], pc_e[1:0]};

    assign hit_f = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

    // Lookups read the pre-update contents, so training shows up one cycle later.
    assign pred_taken_f  = !reset && !stall && hit_f && ctr_q[idx_f][1];
    assign pred_target_f = target_q[idx_f];

    // A taken branch with the wrong predicted target is also a mispredict.
    assign mispredict = br_valid_e &&
                        ((br_taken_e != pred_taken_e) ||
                         (br_taken_e && (pred_target_e != target_e)));

    // Next-PC select: EX jump, then EX mispredict, then hold, then fetch prediction.
    always_comb begin
        pc_src      = SRC_SEQ;
        redirect_pc = '0;
        if (reset) begin
            pc_src      = SRC_SEQ;
            redirect_pc = '0;
        end else if (jump_e) begin
            pc_src      = SRC_JUMP;
            redirect_pc = target_e;
        end else if (mispredict) begin
            if (br_taken_e) begin
                pc_src      = SRC_MISP_TK;
                redirect_pc = target_e;
            end else begin
                pc_src      = SRC_MISP_NT;
                redirect_pc = pc_e + XLEN'(4);
            end
        end else if (stall) begin
            pc_src      = SRC_HOLD;
            redirect_pc = '0;
        end else if (pred_taken_f) begin
            pc_src      = SRC_PREDICT;
            redirect_pc = pred_target_f;
        end
    end

    assign train_jump  = jump_e && !stall;
    assign train_br    = br_valid_e && !stall && !jump_e;
    assign write_entry = train_jump || (train_br && br_taken_e);

    // Counter value written back for the EX-indexed entry; a tag miss restarts it weakly.
    always_comb begin
        ctr_new = ctr_q[idx_e];
        if (train_jump) begin
            ctr_new = 2'b11;
        end else if (hit_e) begin
            ctr_new = br_taken_e ? ctr_inc(ctr_q[idx_e]) : ctr_dec(ctr_q[idx_e]);
        end else begin
            ctr_new = br_taken_e ? 2'b10 : 2'b01;
        end
    end

    // Valid bits and counters: cleared to weakly-not-taken on reset, trained from EX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            if (train_jump || train_br) begin
                ctr_q[idx_e] <= ctr_new;
            end
            if (write_entry) begin
                valid_q[idx_e] <= 1'b1;
            end else if (train_br && !hit_e) begin
                valid_q[idx_e] <= 1'b0;
            end
        end
    end

    // BTB tag and target capture on taken branches and jumps.
    always_ff @(posedge clk) begin
        if (write_entry) begin
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= target_e;
        end
    end

`ifdef BRU_PERF_EN
    function automatic logic [31:0] cnt_sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    // Event counters for trained branches and detected mispredicts, frozen during stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (!stall) begin
            if (br_valid_e) begin
                branch_cnt <= cnt_sat_inc(branch_cnt);
            end
            if (mispredict) begin
                mispredict_cnt <= cnt_sat_inc(mispredict_cnt);
            end
        end
    end
`endif

endmodule
